// File: rtl/frame_scan_ctrl.sv
// Raster-scan coordinate generator: emits x/y beats over a valid/ready stream with
// sop/eop markers, inter-frame blanking, a programmable frame count and sticky abort.
module frame_scan_ctrl #(
    parameter int LINE_WIDTH = 640,
    parameter int ROW_NUMBER = 480,
    parameter int V_BLANK    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  frame_count,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        sop,
    output logic        eop,
    output logic        frame_done,
    output logic [7:0]  frames_sent,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SCAN, GAP} state_t;

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic        abort_flag;
    logic [15:0] gap_cnt;

    logic        xfer, last_x, last_y, eop_xfer, more, abort_now;
    logic [7:0]  frames_inc;

    assign busy       = (state != IDLE);
    assign out_valid  = (state == SCAN);
    assign last_x     = (x == 16'(LINE_WIDTH - 1));
    assign last_y     = (y == 16'(ROW_NUMBER - 1));
    assign sop        = out_valid && (x == 16'd0) && (y == 16'd0);
    assign eop        = out_valid && last_x && last_y;
    assign xfer       = out_valid && out_ready;
    assign eop_xfer   = xfer && last_x && last_y;
    assign frames_inc = frames_sent + 8'd1;
    assign more       = (cnt == 8'd0) || (frames_inc < cnt);
    // An abort arriving on the eop cycle itself still ends the run after this frame.
    assign abort_now  = abort_flag || abort;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = SCAN;
            SCAN: begin
                if (eop_xfer) begin
                    if (more && !abort_now) state_nxt = (V_BLANK > 0) ? GAP : SCAN;
                    else                    state_nxt = IDLE;
                end
            end
            GAP: begin
                if (abort_now)                            state_nxt = IDLE;
                else if (gap_cnt == 16'(V_BLANK - 1))     state_nxt = SCAN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            x           <= 16'd0;
            y           <= 16'd0;
            cnt         <= 8'd0;
            abort_flag  <= 1'b0;
            frames_sent <= 8'd0;
            frame_done  <= 1'b0;
            gap_cnt     <= 16'd0;
        end else begin
            state      <= state_nxt;
            frame_done <= eop_xfer;
            gap_cnt    <= (state == GAP) ? gap_cnt + 16'd1 : 16'd0;

            if (state == IDLE) begin
                if (start) begin
                    cnt         <= frame_count;
                    frames_sent <= 8'd0;
                    abort_flag  <= 1'b0;
                    x           <= 16'd0;
                    y           <= 16'd0;
                end
            end else begin
                abort_flag <= (state_nxt == IDLE) ? 1'b0 : (abort_flag || abort);
            end

            if (xfer) begin
                if (last_x) begin
                    x <= 16'd0;
                    y <= last_y ? 16'd0 : y + 16'd1;
                end else begin
                    x <= x + 16'd1;
                end
            end

            if (eop_xfer) frames_sent <= frames_inc;
        end
    end

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Scoreboard bench for frame_scan_ctrl: stimulus pushes expected beats per run,
// a negedge monitor pops and compares every transferred beat and the frame_done timing.
module tb_frame_scan_ctrl;
    localparam int LW = 4, RN = 3, VB = 2, FB = LW * RN;

    logic        clk = 0, rst_n = 0, start = 0, abort = 0, out_ready = 0;
    logic [7:0]  frame_count = 0;
    logic        out_valid, sop, eop, frame_done, busy;
    logic [15:0] x, y;
    logic [7:0]  frames_sent;

    frame_scan_ctrl #(.LINE_WIDTH(LW), .ROW_NUMBER(RN), .V_BLANK(VB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .frame_count(frame_count),
        .out_valid(out_valid), .out_ready(out_ready), .x(x), .y(y), .sop(sop), .eop(eop),
        .frame_done(frame_done), .frames_sent(frames_sent), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] x, y;
        logic        sop, eop;
        logic [15:0] gap;
    } beat_t;

    beat_t expq[$];
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: beat order, hold-under-backpressure, blanking length, frame_done timing.
    logic        done_exp = 0, pstall = 0;
    logic [15:0] px = 0, py = 0;
    int          gapc = 0;
    beat_t       e;
    always @(negedge clk) begin
        if (!rst_n) begin
            done_exp = 0; pstall = 0; gapc = 0;
        end else begin
            chk("frame_done", frame_done, done_exp);
            if (pstall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_x", x, px);
                chk("hold_y", y, py);
            end
            if (busy && !out_valid) gapc++;
            done_exp = 0;
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: got x=%0d y=%0d expected no beat", x, y);
                end else begin
                    e = expq.pop_front();
                    chk("beat_x", x, e.x);
                    chk("beat_y", y, e.y);
                    chk("beat_sop", sop, e.sop);
                    chk("beat_eop", eop, e.eop);
                    chk("blank_cycles", gapc, e.gap);
                    done_exp = e.eop;
                end
                gapc = 0;
            end
            pstall = out_valid && !out_ready;
            px = x; py = y;
        end
    end

    // One launch: expected beats come from the frame count and abort point alone.
    task automatic run(input int cnt, input int abort_at, input int stall_at, input bit rnd,
                       input bit smid, input bit abw, input int rst_at);
        int nf, n, cyc, stall_left;
        bit xf, aborted, smid_done, stalled;
        n = 0; cyc = 0; stall_left = 0; aborted = 0; smid_done = 0; stalled = 0;
        nf = cnt;
        if (abort_at >= 0) begin
            int a = abort_at / FB + 1;
            if (cnt == 0 || a < cnt) nf = a;
        end
        for (int f = 0; f < nf; f++)
            for (int yy = 0; yy < RN; yy++)
                for (int xx = 0; xx < LW; xx++) begin
                    beat_t b;
                    b.x = 16'(xx); b.y = 16'(yy);
                    b.sop = (xx == 0 && yy == 0);
                    b.eop = (xx == LW - 1 && yy == RN - 1);
                    b.gap = (f > 0 && b.sop) ? 16'(VB) : 16'd0;
                    expq.push_back(b);
                end
        @(posedge clk); #1;
        start = 1; frame_count = 8'(cnt); abort = abw;
        out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        @(posedge clk); #1;
        start = 0; abort = 0;
        while (cyc < 3000 && busy) begin
            abort = 0; start = 0;
            if (rst_at >= 0 && n == rst_at) begin
                #2 rst_n = 0;
                #1;
                chk("rst_valid", out_valid, 0);
                chk("rst_x", x, 0);
                chk("rst_y", y, 0);
                chk("rst_busy", busy, 0);
                chk("rst_frame_done", frame_done, 0);
                chk("rst_frames_sent", frames_sent, 0);
                expq.delete();
                repeat (2) @(posedge clk);
                #1 rst_n = 1;
                return;
            end
            if (abort_at >= 0 && n == abort_at && !aborted) begin abort = 1; aborted = 1; end
            if (smid && !smid_done && n >= 3) begin start = 1; smid_done = 1; end
            if (stall_at >= 0 && n == stall_at && !stalled) begin stall_left = 3; stalled = 1; end
            out_ready = (stall_left > 0) ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (stall_left > 0) stall_left--;
            @(negedge clk) xf = out_valid && out_ready;
            @(posedge clk); #1;
            if (xf) n++;
            cyc++;
        end
        abort = 0; start = 0;
        chk("run_timeout", cyc < 3000, 1);
        chk("frames_sent", frames_sent, 8'(nf));
        chk("beats_left", expq.size(), 0);
        chk("end_busy", busy, 0);
        chk("end_valid", out_valid, 0);
    endtask

    initial begin
        // Reset values, then idle with no start.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", out_valid, 0);
        chk("reset_xy", {x, y}, 0);
        chk("reset_sop_eop", {sop, eop}, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_frames_sent", frames_sent, 0);
        chk("reset_busy", busy, 0);
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_valid", out_valid, 0);
            chk("idle_busy", busy, 0);
        end
        run(1, -1, -1, 0, 0, 0, -1);   // single frame, full throughput
        run(1, -1, 5, 0, 0, 0, -1);    // 3-cycle stall at (1,1)
        run(2, -1, -1, 0, 0, 0, -1);   // two frames with blanking
        run(0, 6, -1, 0, 1, 0, -1);    // continuous, abort at (2,1), mid-frame start ignored
        run(1, -1, -1, 0, 0, 1, -1);   // start and abort together: abort dropped
        run(1, -1, -1, 0, 0, 0, 9);    // reset at (1,2)
        run(1, -1, -1, 0, 0, 0, -1);   // clean frame after reset
        for (int i = 0; i < 30; i++) begin
            int cnt, ab, lim;
            cnt = $urandom_range(0, 3);
            ab = -1;
            if (cnt == 0 || $urandom_range(0, 2) == 0) begin
                lim = (cnt == 0) ? 3 * FB : cnt * FB;
                do ab = $urandom_range(1, lim - 1); while (ab % FB == 0);
            end
            run(cnt, ab, -1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), -1);
        end
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_scan_ctrl.md
Name: frame_scan_ctrl

Overview:
Sequences a raster scan of LINE_WIDTH x ROW_NUMBER pixels per frame. It generates pixel x/y coordinates as a valid/ready stream with start-of-packet and end-of-packet markers, plus inter-frame blanking. The block runs a programmed number of frames, or runs continuously until aborted. It sits upstream of the vision pixel pipeline and drives its coordinate/timing input.

Parameters:
LINE_WIDTH, 640, pixels per line (>=2)
ROW_NUMBER, 480, lines per frame (>=2)
V_BLANK, 2, idle cycles (out_valid=0) between frames; 0 = back-to-back frames

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  launch command, sampled only in IDLE
abort  input  1  stop request; level or pulse, sticky until acted on
frame_count  input  8  frames to run, latched on start; 0 = continuous
out_valid  output  1  coordinate beat valid
out_ready  input  1  downstream accept
x  output  16  pixel column, 0..LINE_WIDTH-1
y  output  16  pixel row, 0..ROW_NUMBER-1
sop  output  1  high on beat x=0,y=0
eop  output  1  high on beat x=LINE_WIDTH-1,y=ROW_NUMBER-1
frame_done  output  1  one-cycle pulse after the eop beat transfers
frames_sent  output  8  completed frames since last start, wraps mod 256
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. out_valid, x, y, sop, eop, frame_done, frames_sent and busy all 0. Latched count and abort flag cleared.
- Transfer: a beat transfers on a cycle where out_valid && out_ready.
- States:
  - IDLE: start=1 latches frame_count, clears frames_sent and the abort flag, and moves to SCAN on the next edge. In that next cycle out_valid=1, x=0, y=0, sop=1. Latency from start to the first valid beat is 1 cycle.
  - SCAN: out_valid=1 continuously.
    - On transfer: x+1. At x=LINE_WIDTH-1, x wraps to 0 and y increments.
    - sop/eop are combinational from x/y while out_valid=1.
    - When the eop beat transfers: frame_done=1 the following cycle, frames_sent increments, x and y return to 0.
    - If another frame is due and abort is not latched: go to GAP if V_BLANK>0, otherwise stay in SCAN with the sop beat presented the next cycle.
    - Otherwise: go to IDLE.
  - GAP: out_valid=0 for exactly V_BLANK cycles, then SCAN with the sop beat. An abort latched in GAP sends the block to IDLE on the next edge.
- Another frame is due when latched count=0, or frames_sent (after increment) < latched count.
- Backpressure: while out_valid=1 and out_ready=0, x, y, sop and eop are held stable. out_valid is never deasserted before a transfer.
- Abort:
  - Latched whenever asserted and busy. Never truncates a frame: the current frame runs to its eop, then the block goes to IDLE.
  - Abort in IDLE is ignored.
  - Start and abort together in IDLE: start wins, and the abort is not latched.
- Start is ignored when not in IDLE.
- Counter widths: x and y are 16-bit. Compare at the parameter limits, never rely on overflow.
- frames_sent holds its value in IDLE until the next start.
- Reset mid-frame: immediate return to the reset values. No partial frame_done.

Test Plan:
(Bench parameters: LINE_WIDTH=4, ROW_NUMBER=3, V_BLANK=2.)
1. Hold rst_n=0 for 2 cycles, then release with no start -> all outputs 0, busy=0, out_valid stays 0.
2. start with frame_count=1, out_ready=1 -> 12 consecutive beats, (x,y) from (0,0) to (3,2). sop on beat 0 only, eop on beat 11 only. frame_done pulses for 1 cycle after beat 11. frames_sent=1, busy=0.
3. Same run with out_ready=0 for 3 cycles while at (1,1) -> x=1, y=1, out_valid=1 held for all 3 cycles, then resumes at (2,1). Still 12 beats total.
4. frame_count=2 -> eop at (3,2), then exactly 2 cycles with out_valid=0, then sop at (0,0). Second eop follows. frames_sent=2, then IDLE.
5. frame_count=0, abort pulsed at (2,1) of frame 1 -> frame 1 completes to eop, no GAP, IDLE. frames_sent=1. A start pulse mid-frame is ignored (frames_sent is not cleared).
6. rst_n pulsed low at (1,2) of a running frame -> out_valid, x, y and busy are 0 asynchronously (before the next edge). No frame_done. A subsequent start runs a clean frame from (0,0).
